// File: rtl/mtsp_trds_scheduler.sv
// Multi-thread fetch scheduler: round-robin fetch offers, per-thread PC/state,
// branch/end/wait handling and a barrier that releases once only SYNC/IDLE threads remain.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | thread not running
// ST_READY  | eligible to be offered to fetch
// ST_ISSUED | granted to fetch, awaiting its PC operation
// ST_WAIT   | parked on a memory transaction until PC_nAWAKE
// ST_SYNC   | parked at the barrier
module mtsp_trds_scheduler #(
    parameter int TRD_COUNT = 12,
    parameter int PC_WIDTH  = 16
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             IF_READY,
    output logic                             IF_VALID,
    output logic [TRD_COUNT-1:0]             IF_TRD,
    output logic [PC_WIDTH-1:0]              IF_PC,
    input  logic                             PC_nEN,
    input  logic [TRD_COUNT-1:0]             PC_nTRD,
    input  logic [2:0]                       PC_BOP,
    input  logic [PC_WIDTH-1:0]              PC_NEXT,
    input  logic                             PC_nWAIT,
    input  logic [TRD_COUNT-1:0]             PC_nAWAKE,
    output logic                             TRD_BUSY,
    output logic [$clog2(TRD_COUNT+1)-1:0]   TRD_BUSY_CNT,
    output logic                             TRD_SYNC,
    output logic                             TRD_ERR
);

    localparam int PTR_W = $clog2(TRD_COUNT);
    localparam int CNT_W = $clog2(TRD_COUNT + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_ISSUED = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SYNC   = 3'd4
    } trd_state_e;

    localparam logic [1:0] BOP_JMP = 2'b00;
    localparam logic [1:0] BOP_ALL = 2'b01;
    localparam logic [1:0] BOP_END = 2'b10;
    localparam logic [1:0] BOP_SEQ = 2'b11;

    trd_state_e          state_q [TRD_COUNT];
    trd_state_e          state_d [TRD_COUNT];
    logic [PC_WIDTH-1:0] pc_q    [TRD_COUNT];
    logic [PC_WIDTH-1:0] pc_d    [TRD_COUNT];
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sync_q, sync_d;
    logic                err_q, err_d;

    logic                offer_found;
    logic [PTR_W-1:0]    offer_idx;
    logic                grant;
    logic [TRD_COUNT-1:0] issued_vec, sync_vec, idle_vec, tgt;
    logic                op_all, op_single, tgt_ok, op_apply, release_bar;

    // Offer: first READY thread at or after the pointer, wrapping.
    always_comb begin
        int idx;
        offer_found = 1'b0;
        offer_idx   = '0;
        idx         = 0;
        for (int k = 0; k < TRD_COUNT; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= TRD_COUNT) idx = idx - TRD_COUNT;
            if (!offer_found && state_q[idx] == ST_READY) begin
                offer_found = 1'b1;
                offer_idx   = PTR_W'(idx);
            end
        end
    end

    assign grant    = offer_found & IF_READY;
    assign IF_VALID = offer_found;
    assign IF_TRD   = offer_found ? (TRD_COUNT'(1) << offer_idx) : '0;
    assign IF_PC    = offer_found ? pc_q[offer_idx] : '0;

    always_comb begin
        issued_vec = '0;
        sync_vec   = '0;
        idle_vec   = '0;
        for (int i = 0; i < TRD_COUNT; i++) begin
            issued_vec[i] = (state_q[i] == ST_ISSUED);
            sync_vec[i]   = (state_q[i] == ST_SYNC);
            idle_vec[i]   = (state_q[i] == ST_IDLE);
        end
    end

    assign tgt         = ~PC_nTRD;
    assign op_all      = !PC_nEN && (PC_BOP[1:0] == BOP_ALL);
    assign op_single   = !PC_nEN && (PC_BOP[1:0] != BOP_ALL);
    assign tgt_ok      = $onehot(tgt) && |(tgt & issued_vec);
    assign op_apply    = op_single && tgt_ok;
    // A broadcast load also resolves any pending barrier, so no pulse then.
    assign release_bar = |sync_vec && &(sync_vec | idle_vec) && !op_all;

    always_comb begin
        ptr_d  = ptr_q;
        err_d  = err_q | (op_single && !tgt_ok);
        sync_d = release_bar;
        busy_d = ~&idle_vec;
        cnt_d  = '0;
        for (int i = 0; i < TRD_COUNT; i++) begin
            state_d[i] = state_q[i];
            pc_d[i]    = pc_q[i];
            if (!idle_vec[i]) cnt_d = cnt_d + CNT_W'(1);
        end

        if (op_all) begin
            for (int i = 0; i < TRD_COUNT; i++) begin
                state_d[i] = ST_READY;
                pc_d[i]    = PC_NEXT;
            end
        end else begin
            if (grant) ptr_d = (int'(offer_idx) == TRD_COUNT - 1) ? '0 : offer_idx + PTR_W'(1);
            for (int i = 0; i < TRD_COUNT; i++) begin
                // Each source acts on a distinct current state, so at most one fires per thread.
                if (grant && offer_idx == PTR_W'(i)) state_d[i] = ST_ISSUED;
                if (op_apply && tgt[i]) begin
                    case (PC_BOP[1:0])
                        BOP_JMP, BOP_SEQ: begin
                            pc_d[i] = PC_NEXT;
                            if (PC_BOP[2])      state_d[i] = ST_SYNC;
                            else if (!PC_nWAIT) state_d[i] = ST_WAIT;
                            else                state_d[i] = ST_READY;
                        end
                        BOP_END: state_d[i] = ST_IDLE;
                        default: state_d[i] = state_q[i];
                    endcase
                end
                if (state_q[i] == ST_WAIT && !PC_nAWAKE[i]) state_d[i] = ST_READY;
                if (release_bar && sync_vec[i])             state_d[i] = ST_READY;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < TRD_COUNT; i++) begin
                state_q[i] <= ST_IDLE;
                pc_q[i]    <= '0;
            end
            ptr_q  <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            sync_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            err_q   <= err_d;
        end
    end

    assign TRD_BUSY     = busy_q;
    assign TRD_BUSY_CNT = cnt_q;
    assign TRD_SYNC     = sync_q;
    assign TRD_ERR      = err_q;

endmodule

// File: doc/mtsp_trds_scheduler.md
MTSP_TRDS_SCHEDULER -- requirements
Module: mtsp_trds_scheduler

Interface
REQ-001 The block SHALL take parameter TRD_COUNT, default 12, meaning the number of hardware threads (range 2..32).
REQ-002 The block SHALL take parameter PC_WIDTH, default 16, meaning the program counter width in bits.
REQ-003 The block SHALL have port CLK  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port IF_READY  input  1  meaning the fetch stage accepts a grant this cycle.
REQ-006 The block SHALL have port IF_VALID  output  1  meaning a thread is offered for fetch.
REQ-007 The block SHALL have port IF_TRD  output  TRD_COUNT  meaning the one-hot offered thread (all zero when IF_VALID=0).
REQ-008 The block SHALL have port IF_PC  output  PC_WIDTH  meaning the PC of the offered thread (0 when IF_VALID=0).
REQ-009 The block SHALL have port PC_nEN  input  1  meaning the PC operation is valid (active low).
REQ-010 The block SHALL have port PC_nTRD  input  TRD_COUNT  meaning the one-hot target thread of the PC operation (active low).
REQ-011 The block SHALL have port PC_BOP  input  3  meaning the branch operation: [1:0] 00 jmp, 01 all, 10 end, 11 seq; [2] sync barrier.
REQ-012 The block SHALL have port PC_NEXT  input  PC_WIDTH  meaning the next PC.
REQ-013 The block SHALL have port PC_nWAIT  input  1  meaning the thread parks for a memory transaction (active low).
REQ-014 The block SHALL have port PC_nAWAKE  input  TRD_COUNT  meaning per-thread wake from WAIT (active low).
REQ-015 The block SHALL have port TRD_BUSY  output  1  meaning the registered OR of all non-IDLE threads.
REQ-016 The block SHALL have port TRD_BUSY_CNT  output  clog2(TRD_COUNT+1)  meaning the registered count of non-IDLE threads.
REQ-017 The block SHALL have port TRD_SYNC  output  1  meaning a one-cycle pulse on barrier release.
REQ-018 The block SHALL have port TRD_ERR  output  1  meaning a sticky flag set by an illegal PC operation.

Function
REQ-019 Each thread SHALL hold a PC register and a state from {IDLE, READY, ISSUED, WAIT, SYNC}.
REQ-020 The fetch offer SHALL be combinational from registered state: the first READY thread at or after the round-robin pointer, wrapping modulo TRD_COUNT.
REQ-021 On IF_VALID&IF_READY the granted thread SHALL go READY->ISSUED and the pointer SHALL become (granted+1) mod TRD_COUNT at the next edge; with no handshake both SHALL hold.
REQ-022 A PC operation (PC_nEN=0) with BOP[1:0]=01 SHALL load PC_NEXT into every thread, set every thread READY, and override any same-cycle grant or awake.
REQ-023 Any other PC operation SHALL target exactly one ISSUED thread; zero or multiple targets, or a non-ISSUED target, SHALL ignore the operation and set TRD_ERR.
REQ-024 jmp and seq SHALL load PC_NEXT; the thread SHALL then go to WAIT if PC_nWAIT=0, otherwise READY.
REQ-025 end SHALL set the thread IDLE and leave its PC unchanged.
REQ-026 BOP[2]=1 with jmp or seq SHALL load PC_NEXT and move the thread to SYNC, taking precedence over PC_nWAIT.
REQ-027 When at least one thread is SYNC and every thread is IDLE or SYNC, all SYNC threads SHALL go READY at the next edge and TRD_SYNC SHALL be 1 for that one cycle.
REQ-028 A lone thread entering SYNC SHALL be released on the following cycle (one-cycle barrier).
REQ-029 A thread in WAIT SHALL go READY at the edge where PC_nAWAKE[i]=0; PC_nAWAKE to a thread in any other state SHALL be ignored.
REQ-030 A grant and a PC operation to different threads in the same cycle SHALL both take effect.
REQ-031 TRD_BUSY and TRD_BUSY_CNT SHALL reflect the state one edge earlier (one-cycle latency).

Reset
REQ-032 While RST=1 at an edge: all threads IDLE, all PCs 0, pointer 0, TRD_BUSY=0, TRD_BUSY_CNT=0, TRD_SYNC=0, TRD_ERR=0; IF_VALID=0 follows combinationally.
REQ-033 RST asserted mid-operation SHALL discard pending grants, barriers and waits with no residual pulse.

Verification
REQ-034 After reset, all with PC_NEXT=0x100 -> next cycle IF_VALID=1, IF_TRD=0x001, IF_PC=0x100; with IF_READY held 1, threads 0..11 are offered in turn.
REQ-035 Threads 0 and 5 READY, pointer 3 -> offer is thread 5; after the grant, pointer=6 and the next offer is thread 0.
REQ-036 jmp to ISSUED thread 2 with PC_nWAIT=0, PC_NEXT=0x40 -> thread 2 WAIT and not offered; PC_nAWAKE[2]=0 -> READY with IF_PC=0x40.
REQ-037 Threads 1 and 3 issue sync; thread 7 issues end later -> TRD_SYNC pulses exactly one cycle after thread 7 goes IDLE; threads 1 and 3 READY.
REQ-038 jmp with PC_nTRD=all ones, or targeting a READY thread -> no state change, TRD_ERR=1 until reset.
REQ-039 RST=1 while 4 threads are busy -> next cycle TRD_BUSY=0, TRD_BUSY_CNT=0, IF_VALID=0.
